// File: rtl/sfa_ctrl_multi.sv
//------------------------------------------------------------------------------
// Module   : sfa_ctrl_multi
// Purpose  : AXI-Stream command controller programming NUM_BC block controllers,
//            switch config and PR region. Optional VDONE watchdog: SFA_CTRL_WATCHDOG_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sfa_ctrl_multi #(
  parameter int          NUM_BC         = 2,
  parameter logic [15:0] RET_DONE       = 16'h000A,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  output logic                  sCMD_tready,
  input  logic                  sCMD_tvalid,
  input  logic [31:0]           sCMD_tdata,
  input  logic                  mRet_tready,
  output logic                  mRet_tvalid,
  output logic [31:0]           mRet_tdata,
  output logic                  sPRRet_tready,
  input  logic                  sPRRet_tvalid,
  input  logic [31:0]           sPRRet_tdata,
  input  logic                  mPRCMD_tready,
  output logic                  mPRCMD_tvalid,
  output logic [31:0]           mPRCMD_tdata,
  output logic [NUM_BC-1:0]     BC_EN,
  output logic [16*NUM_BC-1:0]  BC_INDEX,
  output logic [16*NUM_BC-1:0]  BC_SIZE,
  output logic [16*NUM_BC-1:0]  BC_STRIDE,
  output logic [NUM_BC-1:0]     BC_MODE,
  output logic [15:0]           PR_SIZE,
  output logic [2*NUM_BC-1:0]   INCONF,
  output logic                  MUXCONF,
  output logic [1:0]            OUTCONF
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_SET    = 3'd2,
    S_START  = 3'd3,
    S_DONE   = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [3:0]  c_NUM_BC   = 4'(NUM_BC);
  localparam logic [31:0] c_WD_LIMIT = 32'(TIMEOUT_CYCLES - 1);

  state_t                     r_state;
  logic [31:0]                r_instr;
  logic [31:0]                r_ret;
  logic [31:0]                r_prcmd_data;
  logic [NUM_BC-1:0]          r_bc_en;
  logic [NUM_BC-1:0][15:0]    r_bc_index;
  logic [NUM_BC-1:0][15:0]    r_bc_size;
  logic [NUM_BC-1:0][15:0]    r_bc_stride;
  logic [NUM_BC-1:0]          r_bc_mode;
  logic [15:0]                r_pr_size;
  logic [2*NUM_BC-1:0]        r_inconf;
  logic                       r_muxconf;
  logic [1:0]                 r_outconf;
`ifdef SFA_CTRL_WATCHDOG_EN
  logic [31:0]                r_wd_cnt;
`endif

  logic [15:0]                w_opcode;
  logic [3:0]                 w_k;
  logic [3:0]                 w_sub;
  logic [3:0]                 w_bc_idx;
  logic                       w_bc_hit;
  logic [NUM_BC-1:0]          w_mask;
  logic                       w_unused;

  assign w_opcode = r_instr[31:16];
  assign w_k      = w_opcode[7:4];
  assign w_sub    = w_opcode[3:0];
  assign w_bc_idx = w_k - 4'd1;
  assign w_bc_hit = (w_opcode[15:8] == 8'h00) && (w_k >= 4'd1) && (w_k <= c_NUM_BC) &&
                    (w_sub >= 4'd1) && (w_sub <= 4'd4);
  // An all-zero mask is shorthand for "start every block controller".
  assign w_mask   = (r_instr[NUM_BC-1:0] == '0) ? '1 : r_instr[NUM_BC-1:0];
  assign w_unused = ^{sPRRet_tdata[31:16], c_WD_LIMIT};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state      <= S_FETCH;
      r_instr      <= '0;
      r_ret        <= '0;
      r_prcmd_data <= '0;
      r_bc_en      <= '0;
      r_bc_index   <= '0;
      r_bc_size    <= '0;
      r_bc_stride  <= '0;
      r_bc_mode    <= '0;
      r_pr_size    <= '0;
      r_inconf     <= '0;
      r_muxconf    <= 1'b0;
      r_outconf    <= '0;
`ifdef SFA_CTRL_WATCHDOG_EN
      r_wd_cnt     <= '0;
`endif
    end else begin
      r_bc_en <= '0;
      case (r_state)
        S_FETCH: begin
          if (sCMD_tvalid) begin
            r_instr <= sCMD_tdata;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_state <= S_FETCH;
          if (w_opcode == 16'h0001) begin
            r_state <= S_SET;
          end else if (w_opcode == 16'h0003) begin
            r_state      <= S_START;
            r_bc_en      <= w_mask;
            r_prcmd_data <= {31'b0, r_muxconf};
          end else if (w_opcode == 16'h0008) begin
            r_state  <= S_DONE;
`ifdef SFA_CTRL_WATCHDOG_EN
            r_wd_cnt <= '0;
`endif
          end else if (w_opcode == 16'h0010) begin
            r_pr_size <= r_instr[15:0];
          end else if (w_bc_hit) begin
            for (int k = 0; k < NUM_BC; k++) begin
              if (w_bc_idx == 4'(k)) begin
                case (w_sub)
                  4'd1:    r_bc_index[k]  <= r_instr[15:0];
                  4'd2:    r_bc_size[k]   <= r_instr[15:0];
                  4'd3:    r_bc_stride[k] <= r_instr[15:0];
                  default: r_bc_mode[k]   <= r_instr[0];
                endcase
              end
            end
          end else begin
            r_ret   <= {16'hEEEE, w_opcode};
            r_state <= S_WB;
          end
        end
        S_SET: begin
          for (int k = 0; k < NUM_BC; k++) begin
            r_inconf[2*k +: 2] <= r_instr[2*k+8 +: 2];
          end
          r_muxconf <= r_instr[2];
          r_outconf <= r_instr[1:0];
          r_state   <= S_FETCH;
        end
        S_START: begin
          if (!r_muxconf || mPRCMD_tready) begin
            r_state <= S_FETCH;
          end
        end
        S_DONE: begin
          // A PR completion arriving on the timeout cycle takes priority.
          if (sPRRet_tvalid) begin
            r_ret   <= {RET_DONE, sPRRet_tdata[15:0]};
            r_state <= S_WB;
`ifdef SFA_CTRL_WATCHDOG_EN
          end else if (r_wd_cnt == c_WD_LIMIT) begin
            r_ret   <= {16'h000E, 16'h0000};
            r_state <= S_WB;
          end else begin
            r_wd_cnt <= r_wd_cnt + 32'd1;
`endif
          end
        end
        S_WB: begin
          if (mRet_tready) begin
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign sCMD_tready   = (r_state == S_FETCH);
  assign sPRRet_tready = (r_state == S_DONE);
  assign mRet_tvalid   = (r_state == S_WB);
  assign mRet_tdata    = r_ret;
  assign mPRCMD_tvalid = (r_state == S_START) && r_muxconf;
  assign mPRCMD_tdata  = r_prcmd_data;
  assign BC_EN         = r_bc_en;
  assign BC_INDEX      = r_bc_index;
  assign BC_SIZE       = r_bc_size;
  assign BC_STRIDE     = r_bc_stride;
  assign BC_MODE       = r_bc_mode;
  assign PR_SIZE       = r_pr_size;
  assign INCONF        = r_inconf;
  assign MUXCONF       = r_muxconf;
  assign OUTCONF       = r_outconf;

endmodule

`default_nettype wire

// File: tb/tb_sfa_ctrl_multi.sv
//------------------------------------------------------------------------------
// Module   : tb_sfa_ctrl_multi
// Purpose  : Randomised self-checking bench for sfa_ctrl_multi against a
//            command-level reference model. Honours SFA_CTRL_WATCHDOG_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sfa_ctrl_multi;

  localparam int          NB = 2;
  localparam logic [15:0] RD = 16'h000A;
`ifdef SFA_CTRL_WATCHDOG_EN
  localparam int          TO = 16;
  localparam bit          WD = 1'b1;
`else
  localparam int          TO = 1024;
  localparam bit          WD = 1'b0;
`endif

  logic              ACLK, ARESETN;
  logic              sCMD_tready, sCMD_tvalid;
  logic [31:0]       sCMD_tdata;
  logic              mRet_tready, mRet_tvalid;
  logic [31:0]       mRet_tdata;
  logic              sPRRet_tready, sPRRet_tvalid;
  logic [31:0]       sPRRet_tdata;
  logic              mPRCMD_tready, mPRCMD_tvalid;
  logic [31:0]       mPRCMD_tdata;
  logic [NB-1:0]     BC_EN, BC_MODE;
  logic [16*NB-1:0]  BC_INDEX, BC_SIZE, BC_STRIDE;
  logic [15:0]       PR_SIZE;
  logic [2*NB-1:0]   INCONF;
  logic              MUXCONF;
  logic [1:0]        OUTCONF;

  sfa_ctrl_multi #(.NUM_BC(NB), .RET_DONE(RD), .TIMEOUT_CYCLES(TO)) u_dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .sCMD_tready(sCMD_tready), .sCMD_tvalid(sCMD_tvalid), .sCMD_tdata(sCMD_tdata),
    .mRet_tready(mRet_tready), .mRet_tvalid(mRet_tvalid), .mRet_tdata(mRet_tdata),
    .sPRRet_tready(sPRRet_tready), .sPRRet_tvalid(sPRRet_tvalid), .sPRRet_tdata(sPRRet_tdata),
    .mPRCMD_tready(mPRCMD_tready), .mPRCMD_tvalid(mPRCMD_tvalid), .mPRCMD_tdata(mPRCMD_tdata),
    .BC_EN(BC_EN), .BC_INDEX(BC_INDEX), .BC_SIZE(BC_SIZE), .BC_STRIDE(BC_STRIDE),
    .BC_MODE(BC_MODE), .PR_SIZE(PR_SIZE), .INCONF(INCONF), .MUXCONF(MUXCONF), .OUTCONF(OUTCONF)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: architectural state as plain arrays.
  logic [15:0]     m_idx [NB];
  logic [15:0]     m_size[NB];
  logic [15:0]     m_strd[NB];
  logic [NB-1:0]   m_mode;
  logic [15:0]     m_prsize;
  logic [2*NB-1:0] m_inconf;
  logic            m_mux;
  logic [1:0]      m_out;
  logic [31:0]     m_ret, m_prdata;

  task automatic model_reset();
    for (int k = 0; k < NB; k++) begin
      m_idx[k] = '0; m_size[k] = '0; m_strd[k] = '0;
    end
    m_mode = '0; m_prsize = '0; m_inconf = '0; m_mux = 1'b0; m_out = '0;
    m_ret = '0; m_prdata = '0;
  endtask

  task automatic check_cfg(input string tag);
    logic [16*NB-1:0] ei, es, et;
    for (int k = 0; k < NB; k++) begin
      ei[16*k +: 16] = m_idx[k];
      es[16*k +: 16] = m_size[k];
      et[16*k +: 16] = m_strd[k];
    end
    chk({tag, ".BC_INDEX"},  BC_INDEX,  ei);
    chk({tag, ".BC_SIZE"},   BC_SIZE,   es);
    chk({tag, ".BC_STRIDE"}, BC_STRIDE, et);
    chk({tag, ".BC_MODE"},   BC_MODE,   m_mode);
    chk({tag, ".PR_SIZE"},   PR_SIZE,   m_prsize);
    chk({tag, ".INCONF"},    INCONF,    m_inconf);
    chk({tag, ".MUXCONF"},   MUXCONF,   m_mux);
    chk({tag, ".OUTCONF"},   OUTCONF,   m_out);
    chk({tag, ".RET"},       mRet_tdata, m_ret);
    chk({tag, ".PRCMD"},     mPRCMD_tdata, m_prdata);
  endtask

  // Issues one command and follows it to the next sCMD_tready, comparing
  // handshake timing and side effects with the model.
  task automatic run_cmd(input logic [31:0] cmd, input int pr_stall, input int done_stall,
                         input int ret_stall, input logic [31:0] pr_data);
    logic [15:0]   op;
    logic [15:0]   pl;
    int            k, sub;
    int            e_lat, e_rfirst, e_en_cyc, e_prv;
    bit            e_ret_ok;
    logic [NB-1:0] e_en;
    logic [31:0]   e_ret;
    int            t, en_cyc, prv, dn, rc, rfirst;
    logic [NB-1:0] en_val;
    logic [31:0]   rval;
    bit            pr_bad, r_bad, seen_ready;

    op = cmd[31:16]; pl = cmd[15:0];
    k = int'(op[7:4]); sub = int'(op[3:0]);
    e_lat = 2; e_rfirst = 0; e_en_cyc = 0; e_en = '0; e_prv = 0; e_ret_ok = 1'b0; e_ret = '0;

    if (op == 16'h0001) begin
      e_lat = 3;
      for (int j = 0; j < NB; j++) m_inconf[2*j +: 2] = pl[2*j+8 +: 2];
      m_mux = pl[2]; m_out = pl[1:0];
    end else if (op == 16'h0003) begin
      e_en_cyc = 1;
      e_en = (pl[NB-1:0] == '0) ? {NB{1'b1}} : pl[NB-1:0];
      m_prdata = {31'b0, m_mux};
      e_prv = m_mux ? pr_stall + 1 : 0;
      e_lat = 3 + (m_mux ? pr_stall : 0);
    end else if (op == 16'h0008) begin
      e_ret_ok = 1'b1;
      if (WD && (done_stall + 1 > TO)) begin
        e_rfirst = TO + 2;
        e_ret = 32'h000E_0000;
      end else begin
        e_rfirst = done_stall + 3;
        e_ret = {RD, pr_data[15:0]};
      end
      e_lat = e_rfirst + ret_stall + 1;
    end else if (op == 16'h0010) begin
      m_prsize = pl;
    end else if (op[15:8] == 8'h00 && k >= 1 && k <= NB && sub >= 1 && sub <= 4) begin
      case (sub)
        1: m_idx[k-1]  = pl;
        2: m_size[k-1] = pl;
        3: m_strd[k-1] = pl;
        default: m_mode[k-1] = pl[0];
      endcase
    end else begin
      e_ret_ok = 1'b1;
      e_ret = {16'hEEEE, op};
      e_rfirst = 2;
      e_lat = 3 + ret_stall;
    end
    if (e_ret_ok) m_ret = e_ret;

    chk("cmd_ready", sCMD_tready, 1'b1);
    sCMD_tvalid = 1'b1; sCMD_tdata = cmd;
    @(posedge ACLK); #1;
    sCMD_tvalid = 1'b0; sCMD_tdata = $urandom;

    en_cyc = 0; prv = 0; dn = 0; rc = 0; rfirst = 0; en_val = '0; rval = '0;
    pr_bad = 1'b0; r_bad = 1'b0; seen_ready = 1'b0; t = 1;
    while (t <= 400) begin
      mPRCMD_tready = 1'($urandom_range(0, 1));
      mRet_tready   = 1'($urandom_range(0, 1));
      sPRRet_tvalid = 1'b0;
      if (BC_EN != '0) begin en_cyc++; en_val = BC_EN; end
      if (mPRCMD_tvalid) begin
        prv++;
        if (mPRCMD_tdata !== m_prdata) pr_bad = 1'b1;
        mPRCMD_tready = (prv > pr_stall);
      end
      if (sPRRet_tready) begin
        dn++;
        if (dn > done_stall) begin sPRRet_tvalid = 1'b1; sPRRet_tdata = pr_data; end
      end
      if (mRet_tvalid) begin
        rc++;
        if (rc == 1) begin rfirst = t; rval = mRet_tdata; end
        else if (mRet_tdata !== rval) r_bad = 1'b1;
        mRet_tready = (rc > ret_stall);
      end
      if (sCMD_tready) begin seen_ready = 1'b1; break; end
      @(posedge ACLK); #1;
      t++;
    end
    mPRCMD_tready = 1'b0; mRet_tready = 1'b0; sPRRet_tvalid = 1'b0;

    chk("no_hang", seen_ready, 1'b1);
    chk("latency", t, e_lat);
    chk("en_cycles", en_cyc, e_en_cyc);
    if (e_en_cyc != 0) chk("en_mask", en_val, e_en);
    chk("prcmd_cycles", prv, e_prv);
    chk("prcmd_data_ok", pr_bad, 1'b0);
    if (e_ret_ok) begin
      chk("ret_first", rfirst, e_rfirst);
      chk("ret_cycles", rc, ret_stall + 1);
      chk("ret_value", rval, e_ret);
      chk("ret_stable", r_bad, 1'b0);
    end else begin
      chk("ret_none", rc, 0);
    end
    check_cfg("cfg");
  endtask

  logic [31:0] rcmd;
  logic [15:0] rop;
  int          sel, ds;

  initial begin
    ARESETN = 1'b0; sCMD_tvalid = 1'b0; sCMD_tdata = '0; mRet_tready = 1'b0;
    sPRRet_tvalid = 1'b0; sPRRet_tdata = '0; mPRCMD_tready = 1'b0;
    model_reset();
    #1;
    chk("rst.cmd_ready", sCMD_tready, 1'b1);
    chk("rst.valids", {mRet_tvalid, sPRRet_tready, mPRCMD_tvalid, BC_EN}, '0);
    check_cfg("rst");
    @(posedge ACLK); @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    chk("post_rst.cmd_ready", sCMD_tready, 1'b1);

    run_cmd(32'h0021_1234, 0, 0, 0, 0);
    run_cmd(32'h0013_0040, 0, 0, 0, 0);
    chk("dir.bc1_index", BC_INDEX[31:16], 16'h1234);
    chk("dir.bc0_stride", BC_STRIDE[15:0], 16'h0040);
    run_cmd(32'h0001_0D06, 0, 0, 0, 0);
    chk("dir.inconf", INCONF, 4'b1101);
    run_cmd(32'h0003_0002, 5, 0, 0, 0);
    run_cmd(32'h0001_0000, 0, 0, 0, 0);
    run_cmd(32'h0003_0000, 0, 0, 0, 0);
    run_cmd(32'h0008_0000, 0, 2, 3, 32'h0000_00AB);
    chk("dir.done_ret", mRet_tdata, 32'h000A_00AB);
    run_cmd(32'h0031_5555, 0, 0, 1, 0);
    run_cmd(32'h7777_0000, 0, 0, 0, 0);
    run_cmd(32'h0015_0000, 0, 0, 0, 0);
    run_cmd(32'h0010_BEEF, 0, 0, 0, 0);
`ifdef SFA_CTRL_WATCHDOG_EN
    run_cmd(32'h0008_0000, 0, 1000, 2, 32'h0000_0011);
    run_cmd(32'h0008_0000, 0, TO - 1, 0, 32'h1234_0077);
`endif

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      rcmd[15:0] = 16'($urandom);
      case (sel)
        0, 1, 9: begin
          rop = {8'h00, 4'($urandom_range(1, NB)), 4'($urandom_range(1, 4))};
        end
        2: rop = 16'h0010;
        3: rop = 16'h0001;
        4: rop = 16'h0003;
        5: rop = 16'h0008;
        6: rop = 16'($urandom);
        7: rop = {8'h00, 4'(NB + 1), 4'($urandom_range(1, 4))};
        default: rop = {8'h00, 4'($urandom_range(1, NB)), 4'($urandom_range(5, 15))};
      endcase
      rcmd[31:16] = rop;
      ds = $urandom_range(0, 8);
      if (WD && $urandom_range(0, 4) == 0) ds = 500;
      run_cmd(rcmd, $urandom_range(0, 6), ds, $urandom_range(0, 4), $urandom);
    end

    // Asynchronous reset while a VDONE is waiting on the PR region.
    run_cmd(32'h0001_0F07, 0, 0, 0, 0);
    sCMD_tvalid = 1'b1; sCMD_tdata = 32'h0008_0000;
    @(posedge ACLK); #1;
    sCMD_tvalid = 1'b0;
    @(posedge ACLK); @(posedge ACLK); #1;
    chk("abort.in_done", sPRRet_tready, 1'b1);
    #2;
    ARESETN = 1'b0;
    model_reset();
    #1;
    chk("abort.cmd_ready", sCMD_tready, 1'b1);
    chk("abort.valids", {mRet_tvalid, sPRRet_tready, mPRCMD_tvalid, BC_EN}, '0);
    check_cfg("abort");
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    run_cmd(32'h0022_00C3, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
